// File: rtl/tcdm_xbar_pkg.sv
// tcdm_xbar_pkg
//   Shared definitions for the TCDM crossbar node and its round-robin
//   arbiter: index-width helper and the request payload layout.
package tcdm_xbar_pkg;

    // Width of an index into N items; never less than one bit so that
    // single-entry configurations still get a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 32;

    // Aggregated request payload forwarded through an output arbiter.
    // The node re-declares the same {addr, wdata} layout with its own
    // parameterised widths; this one matches the default build.
    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] wdata;
    } xbar_payload_t;

endpackage

// File: rtl/tcdm_xbar_node_rr_arb.sv
// rr_arb_node
//   Round-robin arbiter for one crossbar output. Fully combinational
//   request/grant path; the priority pointer advances past the winner
//   only on a completed handshake (req_o && gnt_i).
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req_i         per-input request
//   gnt_o         per-input grant (only the winner, equal to gnt_i)
//   data_i        per-input payload
//   req_o         OR of all requests
//   gnt_i         grant from the downstream slave
//   data_o        winner's payload (input 0's payload when idle)
//   idx_o         winner index
module rr_arb_node
    import tcdm_xbar_pkg::*;
#(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_i,
    output logic [NumReq-1:0]                   gnt_o,
    input  logic [NumReq-1:0][DataWidth-1:0]    data_i,
    output logic                                req_o,
    input  logic                                gnt_i,
    output logic [DataWidth-1:0]                data_o,
    output logic [idx_width(NumReq)-1:0]        idx_o
);

    localparam int unsigned IdxW = idx_width(NumReq);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] win;
    logic [IdxW-1:0] cand;
    logic            found;

    // Search upward from the pointer; NumReq is a power of two so the
    // index wraps naturally in IdxW bits.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = ptr_q + IdxW'(i);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign req_o  = |req_i;
    assign data_o = data_i[win];
    assign idx_o  = win;

    always_comb begin
        gnt_o      = '0;
        gnt_o[win] = gnt_i & found;
    end

    if (NumReq > 1) begin : g_ptr
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ptr_q <= '0;
            end else if (req_o && gnt_i) begin
                ptr_q <= win + IdxW'(1);
            end
        end
    end else begin : g_no_ptr
        assign ptr_q = '0;
    end

endmodule

// File: rtl/tcdm_xbar_node.sv
// tcdm_xbar_node
//   NumIn x NumOut crossbar node for the TCDM/Clos interconnect.
//   Each master is steered to one output by its address MSBs; each output
//   picks one master round-robin; read data returns MemLatency cycles later
//   through a per-master delayed bank-select mux.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req_i         master requests              add_i    master addresses
//   wdata_i       master write data            gnt_o    master grants (comb.)
//   rdata_o       read data to masters
//   req_o         slave requests               gnt_i    slave grants
//   add_o         forwarded addresses          wdata_o  forwarded write data
//   rdata_i       slave read data
module tcdm_xbar_node
    import tcdm_xbar_pkg::*;
#(
    parameter int unsigned NumIn      = 4,
    parameter int unsigned NumOut     = 4,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned MemLatency = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumIn-1:0]                   req_i,
    input  logic [NumIn-1:0][AddrWidth-1:0]    add_i,
    input  logic [NumIn-1:0][DataWidth-1:0]    wdata_i,
    output logic [NumIn-1:0]                   gnt_o,
    output logic [NumIn-1:0][DataWidth-1:0]    rdata_o,
    output logic [NumOut-1:0]                  req_o,
    input  logic [NumOut-1:0]                  gnt_i,
    output logic [NumOut-1:0][AddrWidth-1:0]   add_o,
    output logic [NumOut-1:0][DataWidth-1:0]   wdata_o,
    input  logic [NumOut-1:0][DataWidth-1:0]   rdata_i
);

    localparam int unsigned SelW = idx_width(NumOut);
    localparam int unsigned InW  = idx_width(NumIn);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
    } payload_t;

    localparam int unsigned PayW = $bits(payload_t);

    if (NumIn == 0 || (NumIn & (NumIn - 1)) != 0) begin : g_bad_num_in
        $fatal(1, "tcdm_xbar_node: NumIn must be a power of two");
    end
    if (NumOut == 0 || (NumOut & (NumOut - 1)) != 0) begin : g_bad_num_out
        $fatal(1, "tcdm_xbar_node: NumOut must be a power of two");
    end
    if (NumOut > 1 && AddrWidth < SelW) begin : g_bad_addr
        $fatal(1, "tcdm_xbar_node: AddrWidth too small for NumOut");
    end

    logic [NumIn-1:0][SelW-1:0]    sel;
    logic [NumIn-1:0][PayW-1:0]    in_pay;
    logic [NumOut-1:0][NumIn-1:0]  arb_req;
    logic [NumOut-1:0][NumIn-1:0]  arb_gnt;
    logic [NumIn-1:0][NumOut-1:0]  gnt_t;
    logic [NumOut-1:0][PayW-1:0]   out_pay;
    logic [NumOut-1:0][InW-1:0]    arb_idx;

    // Per master: bank select, payload packing, response path.
    for (genvar j = 0; j < NumIn; j++) begin : g_master
        if (NumOut > 1) begin : g_sel
            assign sel[j] = add_i[j][AddrWidth-1 -: SelW];
        end else begin : g_sel_const
            assign sel[j] = '0;
        end

        assign in_pay[j] = payload_t'{addr: add_i[j], wdata: wdata_i[j]};
        assign gnt_o[j]  = |gnt_t[j];

        if (MemLatency == 0) begin : g_resp_comb
            assign rdata_o[j] = rdata_i[sel[j]];
        end else begin : g_resp_pipe
            logic [MemLatency-1:0][SelW-1:0] sel_pipe;

            if (MemLatency == 1) begin : g_one
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) sel_pipe <= '0;
                    else       sel_pipe <= sel[j];
                end
            end else begin : g_many
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) sel_pipe <= '0;
                    else       sel_pipe <= {sel_pipe[MemLatency-2:0], sel[j]};
                end
            end

            assign rdata_o[j] = rdata_i[sel_pipe[MemLatency-1]];
        end
    end

    // Decoder: request matrix, and its transpose for the grant return.
    for (genvar k = 0; k < NumOut; k++) begin : g_dec_out
        for (genvar j = 0; j < NumIn; j++) begin : g_dec_in
            assign arb_req[k][j] = req_i[j] && (sel[j] == SelW'(k));
            assign gnt_t[j][k]   = arb_gnt[k][j];
        end
    end

    for (genvar k = 0; k < NumOut; k++) begin : g_slave
        payload_t win_pay;

        rr_arb_node #(
            .NumReq    (NumIn),
            .DataWidth (PayW)
        ) i_arb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .req_i  (arb_req[k]),
            .gnt_o  (arb_gnt[k]),
            .data_i (in_pay),
            .req_o  (req_o[k]),
            .gnt_i  (gnt_i[k]),
            .data_o (out_pay[k]),
            .idx_o  (arb_idx[k])
        );

        assign win_pay    = out_pay[k];
        assign add_o[k]   = win_pay.addr;
        assign wdata_o[k] = win_pay.wdata;

        // A grant, when present, must sit on the reported winner index.
        always_comb begin
            if (arb_gnt[k] != '0) begin
                assert (arb_gnt[k][arb_idx[k]]);
            end
        end
    end

endmodule

// File: tb/tb_tcdm_xbar_node.sv
module tb_tcdm_xbar_node;

    logic              clk;
    logic              rst;
    logic [3:0]        req_i;
    logic [3:0][31:0]  add_i;
    logic [3:0][31:0]  wdata_i;
    logic [3:0]        gnt_i;
    logic [3:0][31:0]  rdata_i;

    logic [3:0]        gnt_o,   gnt_o2;
    logic [3:0][31:0]  rdata_o, rdata_o2;
    logic [3:0]        req_o,   req_o2;
    logic [3:0][31:0]  add_o,   add_o2;
    logic [3:0][31:0]  wdata_o, wdata_o2;

    int vecs;
    int miscompares;

    tcdm_xbar_node #(
        .NumIn(4), .NumOut(4), .AddrWidth(32), .DataWidth(32), .MemLatency(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .add_i(add_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rdata_o(rdata_o), .req_o(req_o), .gnt_i(gnt_i),
        .add_o(add_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
    );

    tcdm_xbar_node #(
        .NumIn(4), .NumOut(4), .AddrWidth(32), .DataWidth(32), .MemLatency(2)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .add_i(add_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o2), .rdata_o(rdata_o2), .req_o(req_o2), .gnt_i(gnt_i),
        .add_o(add_o2), .wdata_o(wdata_o2), .rdata_i(rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        vecs        = 0;
        miscompares = 0;

        // Reset state
        rst        = 1'b1;
        req_i      = '0;
        add_i      = '0;
        wdata_i    = '0;
        gnt_i      = '0;
        rdata_i    = '0;
        rdata_i[0] = 32'h5555_0000;
        rdata_i[1] = 32'h1111_1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_o",    req_o,    4'b0000);
        chk("rst_gnt_o",    gnt_o,    4'b0000);
        chk("rst_rdata_o",  rdata_o,  {4{32'h5555_0000}});
        chk("rst_rdata_o2", rdata_o2, {4{32'h5555_0000}});

        // Combinational path live during reset
        req_i = 4'b0010;
        gnt_i = 4'b0001;
        #1;
        chk("rst_comb_req_o", req_o, 4'b0001);
        chk("rst_comb_gnt_o", gnt_o, 4'b0010);
        req_i = '0;
        gnt_i = '0;
        rst   = 1'b0;
        tick();

        // Single request routed to output 3
        req_i      = 4'b0100;
        add_i[2]   = 32'hC000_0010;
        wdata_i[2] = 32'h0000_00A5;
        gnt_i      = 4'b1111;
        #1;
        chk("t1_req_o",   req_o,      4'b1000);
        chk("t1_add_o3",  add_o[3],   32'hC000_0010);
        chk("t1_wdata_o3", wdata_o[3], 32'h0000_00A5);
        chk("t1_gnt_o",   gnt_o,      4'b0100);
        tick();
        req_i      = '0;
        rdata_i[3] = 32'hDEAD_BEEF;
        #1;
        chk("t1_rdata_o2", rdata_o[2], 32'hDEAD_BEEF);

        // All masters on output 0: rotation 0,1,2,3,0
        add_i = {32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
        req_i = 4'b1111;
        gnt_i = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            e = 4'b0001 << (c % 4);
            #1;
            chk("t2_gnt_o",  gnt_o,    e);
            chk("t2_add_o0", add_o[0], 32'(4 * (c % 4)));
            tick();
        end

        // Masters 1 and 3 on output 2, stalled then granted
        req_i    = 4'b1010;
        add_i    = '0;
        add_i[1] = 32'h8000_0004;
        add_i[3] = 32'h8000_000C;
        gnt_i    = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_stall_req_o", req_o, 4'b0100);
            chk("t4_stall_gnt_o", gnt_o, 4'b0000);
            tick();
        end
        gnt_i = 4'b0100;
        #1;
        chk("t4_first_gnt_o",  gnt_o,    4'b0010);
        chk("t4_first_add_o2", add_o[2], 32'h8000_0004);
        tick();
        #1;
        chk("t4_second_gnt_o",  gnt_o,    4'b1000);
        chk("t4_second_add_o2", add_o[2], 32'h8000_000C);
        tick();

        // Distinct targets granted together
        add_i = {32'hC000_0030, 32'h8000_0020, 32'h4000_0010, 32'h0000_0000};
        req_i = 4'b1111;
        gnt_i = 4'b1111;
        #1;
        chk("t3_gnt_o", gnt_o, 4'b1111);
        chk("t3_req_o", req_o, 4'b1111);
        chk("t3_add_o", add_o, {32'hC000_0030, 32'h8000_0020, 32'h4000_0010, 32'h0000_0000});
        tick();

        // Rotation on output 0 starting from pointer 1, then reset
        add_i = {32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
        gnt_i = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            e = 4'b0001 << ((c + 1) % 4);
            #1;
            chk("t5_rot_gnt_o", gnt_o, e);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("t5_rst_gnt_o", gnt_o, 4'b0001);
        chk("t5_rst_req_o", req_o, 4'b0001);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_post_gnt_o", gnt_o, 4'b0001);
        tick();
        #1;
        chk("t5_next_gnt_o", gnt_o, 4'b0010);

        // Latency-2 response path
        req_i = '0;
        gnt_i = '0;
        add_i = '0;
        tick();
        tick();
        req_i      = 4'b0001;
        add_i[0]   = 32'h4000_0000;
        gnt_i      = 4'b0010;
        rdata_i[0] = 32'hAAAA_0000;
        rdata_i[1] = 32'h0000_1234;
        #1;
        chk("t6_gnt_o2",      gnt_o2,      4'b0001);
        chk("t6_t0_rdata_o2", rdata_o2[0], 32'hAAAA_0000);
        tick();
        req_i    = '0;
        add_i[0] = '0;
        gnt_i    = '0;
        #1;
        chk("t6_t1_rdata_o2", rdata_o2[0], 32'hAAAA_0000);
        chk("t6_t1_rdata_o",  rdata_o[0],  32'h0000_1234);
        tick();
        #1;
        chk("t6_t2_rdata_o2", rdata_o2[0], 32'h0000_1234);
        tick();
        #1;
        chk("t6_t3_rdata_o2", rdata_o2[0], 32'hAAAA_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/tcdm_xbar_node.md
Name: tcdm_xbar_node

Overview:
- Full NumIn x NumOut crossbar node for the TCDM/Clos interconnect; usable as an ingress, middle or egress stage.
- Per master: an address decoder steers the request to one output by the address MSBs, and a response mux returns read data after a fixed memory latency.
- Per output: a round-robin arbiter selects one master's request (address + write data).

Parameters:
- NumIn, 4: number of master ports; power of two, >=1.
- NumOut, 4: number of slave ports; power of two, >=1.
- AddrWidth, 32: address width; must be >= log2(NumOut).
- DataWidth, 32: write/read data width.
- MemLatency, 1: cycles from slave grant to valid rdata_i; 0 allowed.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  NumIn  master request.
- add_i  in  NumIn x AddrWidth  master address.
- wdata_i  in  NumIn x DataWidth  master write data.
- gnt_o  out  NumIn  master grant; combinational from req_i, add_i, gnt_i.
- rdata_o  out  NumIn x DataWidth  read response to master.
- req_o  out  NumOut  slave request.
- gnt_i  in  NumOut  slave grant.
- add_o  out  NumOut x AddrWidth  forwarded address, full width, unmodified.
- wdata_o  out  NumOut x DataWidth  forwarded write data.
- rdata_i  in  NumOut x DataWidth  slave read data.

Behaviour:
- Clocking and reset: one clock domain clk_i; rst_i is asynchronous and active-high.
- Bank select: sel[j] = add_i[j][AddrWidth-1 -: log2(NumOut)].
  - If NumOut==1, sel is the constant 0 (1-bit signal).
- Decoder: master j raises the internal request only toward output sel[j].
  - gnt_o[j] = that output arbiter's grant for input j.
  - gnt_o[j] = 0 when req_i[j] = 0.
- Arbiter (per output k): req_o[k] = OR of all inputs targeting k.
  - Winner = first requesting input at index >= ptr_k, searching upward with wrap-around.
  - add_o[k]/wdata_o[k] carry the winner's add_i/wdata_i.
  - When no request, outputs carry input 0's data and req_o[k] = 0.
  - Grant to winner = gnt_i[k]; all other inputs get 0.
- Pointer update: ptr_k is updated only when req_o[k] && gnt_i[k] in a cycle, to (winner+1) mod NumIn.
  - Otherwise ptr_k holds.
  - No lock: if gnt_i stays low, the winner may change when requests change.
- Arbiter path is fully combinational: zero-cycle request path.
- Response: each master keeps a MemLatency-deep shift register of sel[j], shifting every cycle.
  - rdata_o[j] = rdata_i[sel delayed MemLatency cycles].
  - MemLatency=0: rdata_o[j] = rdata_i[sel[j]] combinationally.
  - rdata_o is meaningful only MemLatency cycles after a granted request; other cycles carry don't-care but deterministic data.
- Reset values: all ptr_k = 0; all sel pipeline stages = 0.
  - During reset, rdata_o[j] = rdata_i[0] (for MemLatency>0).
  - req_o/gnt_o follow their combinational inputs even during reset.
- Simultaneous events: several masters targeting the same output get exactly one grant per cycle.
  - Masters targeting distinct outputs are all granted in the same cycle when each gnt_i is 1.
- NumIn==1: arbiter degenerates to pass-through; pointer is unused.
- Elaboration: fatal if NumIn or NumOut is not a power of two.

Decomposition:
- Shared package tcdm_xbar_pkg holds:
  - helper function for index width (max(1, log2(N))).
  - typedef of the aggregated request payload {addr, wdata}.
- Natural sub-module: rr_arb_node (NumReq, DataWidth).
  - Round-robin arbiter with req/gnt/data inputs, req/gnt/data output and idx_o.
  - Instantiated once per output.
- Decoder/response mux stays inline in the generate loop over masters.

Test Plan:
- Defaults. Master 2 requests add=0xC000_0010 (sel=3) with gnt_i=4'b1111 -> req_o=4'b1000, add_o[3]=0xC000_0010, gnt_o=4'b0100. Drive rdata_i[3]=0xDEAD_BEEF one cycle later -> rdata_o[2]=0xDEAD_BEEF.
- All 4 masters target sel=0 continuously with gnt_i[0]=1 -> grants rotate 0,1,2,3,0 on consecutive cycles; exactly one gnt_o bit high per cycle.
- Masters 0..3 target sel=0..3 respectively, all gnt_i=1 -> gnt_o=4'b1111 in the same cycle, add_o[k] equals add_i[k].
- Masters 1 and 3 contend on output 2 with gnt_i[2]=0 for 3 cycles, then 1 -> req_o[2]=1 throughout. No gnt_o while stalled. Master 1 is granted first, then master 3 on the next granted cycle.
- Assert rst_i mid-rotation, after grants to 0 and 1 -> pointer returns to 0. Next contention of all masters grants master 0 first.
- MemLatency=2 build: grant master 0 to sel=1 at cycle t, rdata_i[1]=0x1234 at t+2 -> rdata_o[0]=0x1234 at t+2.
